// File: rtl/wb_debug_pkg.sv
// Shared constants for the host-side Wishbone debug master: opcodes, status bytes,
// widths and the FSM state encoding.
package wb_debug_pkg;

  localparam int unsigned ADR_W   = 15;
  localparam int unsigned DAT_W   = 8;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned STATE_W = 4;

  localparam logic [DAT_W-1:0] OP_NOP   = 8'h00;
  localparam logic [DAT_W-1:0] OP_READ  = 8'h01;
  localparam logic [DAT_W-1:0] OP_WRITE = 8'h02;

  localparam logic [DAT_W-1:0] ST_OK      = 8'hA5;
  localparam logic [DAT_W-1:0] ST_TIMEOUT = 8'hEE;
  localparam logic [DAT_W-1:0] ST_BAD_OP  = 8'hEF;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_ADDR_HI = 4'd1;
  localparam state_t S_ADDR_LO = 4'd2;
  localparam state_t S_LEN     = 4'd3;
  localparam state_t S_WB_REQ  = 4'd4;
  localparam state_t S_RD_TX   = 4'd5;
  localparam state_t S_WR_RX   = 4'd6;
  localparam state_t S_STATUS  = 4'd7;
  localparam state_t S_DRAIN   = 4'd8;

endpackage

// File: rtl/wb_debug_master_if.sv
// Byte-stream host link plus 8-bit classic Wishbone initiator signals.
interface wb_debug_master_if;

  logic [wb_debug_pkg::DAT_W-1:0] rx_data;
  logic                           rx_valid;
  logic                           rx_ready;
  logic [wb_debug_pkg::DAT_W-1:0] tx_data;
  logic                           tx_valid;
  logic                           tx_ready;
  logic [wb_debug_pkg::ADR_W-1:0] wb_adr_o;
  logic [wb_debug_pkg::DAT_W-1:0] wb_dat_o;
  logic [wb_debug_pkg::DAT_W-1:0] wb_dat_i;
  logic                           wb_we_o;
  logic                           wb_sel_o;
  logic                           wb_stb_o;
  logic                           wb_cyc_o;
  logic                           wb_ack_i;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    output rx_ready, tx_data, tx_valid,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i,
    input  rx_ready, tx_data, tx_valid,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

endinterface

// File: rtl/wb_debug_master.sv
// Converts host command frames (opcode, addr_hi, addr_lo, len, data) into single
// classic Wishbone cycles and returns read data plus a status byte.
module wb_debug_master
  import wb_debug_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  wb_debug_master_if.master  bus,
  output logic               busy
);

  localparam int unsigned      TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             we_q, we_d;
  logic             stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             write_q, write_d;
  logic             drain_q, drain_d;
  logic [DAT_W-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             rx_ready_q, rx_ready_d;
  logic             busy_q, busy_d;
  logic             rx_fire;
  logic             tx_fire;

  assign rx_fire = bus.rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && bus.tx_ready;

  // Next-state and next-output logic; every register holds unless a state acts on it
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    stb_d      = stb_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    write_d    = write_q;
    drain_d    = drain_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          drain_d = 1'b0;
          if (bus.rx_data == OP_READ || bus.rx_data == OP_WRITE) begin
            write_d = (bus.rx_data == OP_WRITE);
            state_d = S_ADDR_HI;
          end else if (bus.rx_data != OP_NOP) begin
            tx_data_d  = ST_BAD_OP;
            tx_valid_d = 1'b1;
            state_d    = S_STATUS;
          end
        end
      end
      S_ADDR_HI: begin
        if (rx_fire) begin
          adr_d   = {bus.rx_data[6:0], adr_q[7:0]};
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_fire) begin
          adr_d   = {adr_q[14:8], bus.rx_data};
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_fire) begin
          cnt_d = (bus.rx_data == '0) ? CNT_W'(256) : CNT_W'(bus.rx_data);
          if (write_q) begin
            state_d = S_WR_RX;
          end else begin
            stb_d   = 1'b1;
            we_d    = 1'b0;
            tmo_d   = '0;
            state_d = S_WB_REQ;
          end
        end
      end
      S_WR_RX: begin
        if (rx_fire) begin
          dat_d   = bus.rx_data;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          tmo_d   = '0;
          state_d = S_WB_REQ;
        end
      end
      S_WB_REQ: begin
        // An ack on the last allowed cycle takes priority over the timeout
        if (bus.wb_ack_i) begin
          stb_d = 1'b0;
          we_d  = 1'b0;
          adr_d = adr_q + ADR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
          if (!write_q) begin
            tx_data_d  = bus.wb_dat_i;
            tx_valid_d = 1'b1;
            state_d    = S_RD_TX;
          end else if (cnt_q == CNT_W'(1)) begin
            tx_data_d  = ST_OK;
            tx_valid_d = 1'b1;
            state_d    = S_STATUS;
          end else begin
            state_d = S_WR_RX;
          end
        end else if (tmo_q == TMO_LAST) begin
          stb_d      = 1'b0;
          we_d       = 1'b0;
          cnt_d      = cnt_q - CNT_W'(1);
          drain_d    = write_q;
          tx_data_d  = ST_TIMEOUT;
          tx_valid_d = 1'b1;
          state_d    = S_STATUS;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RD_TX: begin
        if (tx_fire) begin
          if (cnt_q == '0) begin
            tx_data_d = ST_OK;
            state_d   = S_STATUS;
          end else begin
            tx_valid_d = 1'b0;
            stb_d      = 1'b1;
            tmo_d      = '0;
            state_d    = S_WB_REQ;
          end
        end
      end
      S_STATUS: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          drain_d    = 1'b0;
          state_d    = (drain_q && cnt_q != '0) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (rx_fire) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_IDLE)  || (state_d == S_ADDR_HI) ||
                 (state_d == S_ADDR_LO) || (state_d == S_LEN) ||
                 (state_d == S_WR_RX) || (state_d == S_DRAIN);
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops stb/cyc and any pending tx byte at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      stb_q      <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      write_q    <= 1'b0;
      drain_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      stb_q      <= stb_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      write_q    <= write_d;
      drain_q    <= drain_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_stb_o = stb_q;
  assign bus.wb_cyc_o = stb_q;
  assign bus.wb_sel_o = stb_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_wb_debug_master.sv
// Bench for wb_debug_master: random-latency Wishbone slave, random tx back-pressure,
// and a frame-level reference model of expected bus accesses and response bytes.
module tb_wb_debug_master;
  import wb_debug_pkg::*;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  wb_debug_master_if bus ();

  wb_debug_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem     [0:32767];
  logic [7:0]  ref_mem [0:32767];
  logic [7:0]  got_tx[$];
  logic [7:0]  exp_tx[$];
  logic [23:0] got_log[$];
  logic [23:0] exp_log[$];
  logic [7:0]  wdata[$];

  int nack_idx       = -1;
  int acc_no         = 0;
  bit in_acc         = 1'b0;
  int wait_cnt       = 0;
  int last_abort_len = 0;

  // Wishbone slave: random ack latency, optional never-ack access, stray acks while idle
  always @(negedge clk) begin
    if (reset) begin
      bus.wb_ack_i = 1'b0;
      bus.wb_dat_i = 8'h00;
      in_acc       = 1'b0;
    end else if (bus.wb_stb_o) begin
      if (!in_acc) begin
        in_acc   = 1'b1;
        acc_no++;
        wait_cnt = 0;
      end
      if (acc_no != nack_idx && (wait_cnt >= 6 || $urandom_range(0, 2) == 0)) begin
        bus.wb_ack_i = 1'b1;
        if (bus.wb_we_o) begin
          mem[bus.wb_adr_o] = bus.wb_dat_o;
          got_log.push_back({1'b1, bus.wb_adr_o, bus.wb_dat_o});
        end else begin
          bus.wb_dat_i = mem[bus.wb_adr_o];
          got_log.push_back({1'b0, bus.wb_adr_o, mem[bus.wb_adr_o]});
        end
        in_acc = 1'b0;
      end else begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      if (in_acc) last_abort_len = wait_cnt;
      in_acc       = 1'b0;
      bus.wb_ack_i = ($urandom_range(0, 7) == 0);
      bus.wb_dat_i = 8'($urandom);
    end
  end

  // Host receive side: random tx_ready, collects bytes, checks hold stability
  logic       prev_pend = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      bus.tx_ready = 1'b0;
      prev_pend    = 1'b0;
    end else begin
      checks++;
      assert (bus.wb_cyc_o === bus.wb_stb_o && bus.wb_sel_o === bus.wb_stb_o)
      else begin
        failures++;
        $error("FAIL cyc_sel_eq_stb obs=cyc%b sel%b exp=stb%b", bus.wb_cyc_o, bus.wb_sel_o, bus.wb_stb_o);
      end
      if (prev_pend) begin
        checks++;
        assert (bus.tx_valid === 1'b1 && bus.tx_data === prev_data)
        else begin
          failures++;
          $error("FAIL tx_hold obs=v%b d%02h exp=v1 d%02h", bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      bus.tx_ready = 1'($urandom);
      if (bus.tx_valid && bus.tx_ready) got_tx.push_back(bus.tx_data);
      prev_pend = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    bit rdy;
    done = 1'b0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      rdy = bus.rx_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      else @(negedge clk);
    end
    chk("rx_accept", 32'(done), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  // Waits for all expected response bytes and idle, then compares streams and bus log
  task automatic finish_cmd(input string tag);
    int n;
    n = 0;
    while ((got_tx.size() < exp_tx.size() || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(n < 20000), 32'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_tx_count"}, 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      chk({tag, "_tx_byte"}, 32'(got_tx[i]), 32'(exp_tx[i]));
    chk({tag, "_wb_count"}, 32'(got_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < got_log.size() && i < exp_log.size(); i++)
      chk({tag, "_wb_access"}, 32'(got_log[i]), 32'(exp_log[i]));
    got_tx.delete();
    exp_tx.delete();
    got_log.delete();
    exp_log.delete();
  endtask

  // Reference model: expected accesses and response bytes from frame semantics
  task automatic do_read(input string tag, input logic [14:0] a, input logic [7:0] len, input logic hi7);
    int n;
    logic [14:0] x;
    n = (len == 8'd0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      x = 15'(a + 15'(i));
      exp_log.push_back({1'b0, x, ref_mem[x]});
      exp_tx.push_back(ref_mem[x]);
    end
    exp_tx.push_back(ST_OK);
    send_byte(OP_READ);
    send_byte({hi7, a[14:8]});
    send_byte(a[7:0]);
    send_byte(len);
    finish_cmd(tag);
  endtask

  task automatic do_write(input string tag, input logic [14:0] a, input logic [7:0] len, input logic hi7);
    int n;
    logic [14:0] x;
    n = (len == 8'd0) ? 256 : int'(len);
    wdata.delete();
    for (int i = 0; i < n; i++) begin
      wdata.push_back(8'($urandom));
      x = 15'(a + 15'(i));
      ref_mem[x] = wdata[i];
      exp_log.push_back({1'b1, x, wdata[i]});
    end
    exp_tx.push_back(ST_OK);
    send_byte(OP_WRITE);
    send_byte({hi7, a[14:8]});
    send_byte(a[7:0]);
    send_byte(len);
    for (int i = 0; i < n; i++) send_byte(wdata[i]);
    finish_cmd(tag);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[15'h7FFF] = 8'hAB; ref_mem[15'h7FFF] = 8'hAB;
    mem[15'h0000] = 8'hCD; ref_mem[15'h0000] = 8'hCD;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_adr", 32'(bus.wb_adr_o), 32'h0);
    chk("rst_dat", 32'(bus.wb_dat_o), 32'h0);
    chk("rst_we", 32'(bus.wb_we_o), 32'h0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'h0);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'h0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed write, then read-back across the address wrap
    wdata.delete();
    exp_log.push_back({1'b1, 15'h1000, 8'h12});
    exp_log.push_back({1'b1, 15'h1001, 8'h34});
    ref_mem[15'h1000] = 8'h12;
    ref_mem[15'h1001] = 8'h34;
    exp_tx.push_back(ST_OK);
    send_byte(OP_WRITE); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12);    send_byte(8'h34);
    finish_cmd("write_1000");

    do_read("read_wrap", 15'h7FFF, 8'd2, 1'b1);
    do_read("read_256", 15'h0123, 8'd0, 1'b0);

    // Write that times out on its second byte; third byte must be drained
    nack_idx = acc_no + 2;
    begin
      logic [7:0] d0, d1, d2;
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
      ref_mem[15'h2000] = d0;
      exp_log.push_back({1'b1, 15'h2000, d0});
      exp_tx.push_back(ST_TIMEOUT);
      send_byte(OP_WRITE); send_byte(8'h20); send_byte(8'h00); send_byte(8'h03);
      send_byte(d0); send_byte(d1); send_byte(d2);
    end
    finish_cmd("write_timeout");
    chk("timeout_stb_cycles", 32'(last_abort_len), 32'(TMO));
    nack_idx = -1;
    do_read("read_after_timeout", 15'h2000, 8'd3, 1'b0);

    // Bad opcode, NOP resync, then a normal read
    exp_tx.push_back(ST_BAD_OP);
    send_byte(8'h55);
    send_byte(OP_NOP);
    do_read("read_after_badop", 15'h0456, 8'd3, 1'b1);

    // Random frames
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0)
        do_read("rand_read", 15'($urandom), 8'($urandom_range(1, 6)), 1'($urandom));
      else
        do_write("rand_write", 15'($urandom), 8'($urandom_range(1, 6)), 1'($urandom));
    end

    // Asynchronous reset while a write strobe is outstanding
    nack_idx = acc_no + 1;
    send_byte(OP_WRITE); send_byte(8'h30); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h5A);
    for (int i = 0; i < 50 && !bus.wb_stb_o; i++) @(negedge clk);
    chk("mid_write_stb_high", 32'(bus.wb_stb_o), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_stb", 32'(bus.wb_stb_o), 32'h0);
    chk("async_rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("async_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    nack_idx = -1;
    got_tx.delete();
    got_log.delete();
    do_read("read_after_reset", 15'h3000, 8'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
